// File: rtl/axil_arbiter_rr_wr.sv
// AXI-Lite write-channel arbiter.
// Grants one of NUMBER_MASTER write masters at a time, using fixed priority
// or round-robin. The grant is held until the B-channel handshake of the
// granted master completes, or until an optional timeout forces a release.
module axil_arbiter_rr_wr #(
  parameter int NUMBER_MASTER  = 4,
  parameter int ARB_MODE       = 1,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IDX_W = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [NUMBER_MASTER-1:0] request_wr,
  output logic [NUMBER_MASTER-1:0] grant_wr,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     grant_active,
  input  logic                     s_axil_bvalid,
  input  logic [NUMBER_MASTER-1:0] m_axil_bready,
  output logic                     timeout_err
);

  // Counter only has to reach TIMEOUT_CYCLES-1 before a forced release.
  localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam int TO_LAST = TO_EN ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);
  localparam logic [IDX_W:0]   NM_C      = (IDX_W + 1)'(NUMBER_MASTER);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUMBER_MASTER - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACKN  = 2'd2
  } state_t;

  state_t                     r_state;
  logic [NUMBER_MASTER-1:0]   r_grant;
  logic [IDX_W-1:0]           r_idx;
  logic [IDX_W-1:0]           r_rr_ptr;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_timeout_err;

  state_t                     w_state_nxt;
  logic [NUMBER_MASTER-1:0]   w_grant_nxt;
  logic [IDX_W-1:0]           w_idx_nxt;
  logic [IDX_W-1:0]           w_rr_nxt;
  logic [CNT_W-1:0]           w_cnt_nxt;
  logic                       w_terr_nxt;

  logic [IDX_W-1:0]           w_base;
  logic [2*NUMBER_MASTER-1:0] w_req_dbl;
  logic [NUMBER_MASTER-1:0]   w_req_rot;
  logic                       w_found;
  logic [IDX_W-1:0]           w_off;
  logic [IDX_W:0]             w_sum;
  logic [IDX_W-1:0]           w_win_idx;
  logic [NUMBER_MASTER-1:0]   w_win_oh;
  logic                       w_release;
  logic                       w_timeout;
  logic [IDX_W-1:0]           w_rr_inc;

  // Winner search: rotate requests so the search start sits at bit 0, take
  // the lowest set bit, then map the offset back to an absolute index.
  always_comb begin
    w_base    = (ARB_MODE == 1) ? r_rr_ptr : '0;
    w_req_dbl = {request_wr, request_wr} >> w_base;
    w_req_rot = w_req_dbl[NUMBER_MASTER-1:0];
    w_found   = 1'b0;
    w_off     = '0;
    for (int i = 0; i < NUMBER_MASTER; i++) begin
      if (!w_found && w_req_rot[i]) begin
        w_found = 1'b1;
        w_off   = IDX_W'(i);
      end
    end
    w_sum = {1'b0, w_base} + {1'b0, w_off};
    if (w_sum >= NM_C) begin
      w_sum = w_sum - NM_C;
    end
    w_win_idx = w_sum[IDX_W-1:0];
    w_win_oh  = '0;
    for (int i = 0; i < NUMBER_MASTER; i++) begin
      w_win_oh[i] = w_found && (w_win_idx == IDX_W'(i));
    end
  end

  // Release qualifiers: only the granted master's bready counts.
  always_comb begin
    w_release = s_axil_bvalid && (|(m_axil_bready & r_grant));
    w_timeout = TO_EN && (r_cnt == TO_LAST_C);
    w_rr_inc  = (r_idx == LAST_IDX) ? '0 : (r_idx + IDX_W'(1));
  end

  // Next-state and next-register values for the arbitration FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_idx_nxt   = r_idx;
    w_rr_nxt    = r_rr_ptr;
    w_cnt_nxt   = r_cnt;
    w_terr_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|request_wr) begin
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (w_found) begin
          w_state_nxt = ST_ACKN;
          w_grant_nxt = w_win_oh;
          w_idx_nxt   = w_win_idx;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACKN: begin
        // A real handshake takes precedence over a coincident timeout.
        if (w_release || w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_idx_nxt   = '0;
          w_rr_nxt    = w_rr_inc;
          w_terr_nxt  = !w_release;
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // State and grant registers; reset overrides release and timeout.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_idx         <= '0;
      r_rr_ptr      <= '0;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_idx         <= w_idx_nxt;
      r_rr_ptr      <= w_rr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_timeout_err <= w_terr_nxt;
    end
  end

  assign grant_wr     = r_grant;
  assign grant_idx    = r_idx;
  assign grant_active = (r_state == ST_ACKN);
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_axil_arbiter_rr_wr.sv
// Bench for axil_arbiter_rr_wr: a round-robin and a fixed-priority instance
// share one stimulus stream (4 masters, timeout of 8 ACKN cycles).
module tb_axil_arbiter_rr_wr;

  localparam int NM = 4;
  localparam int TO = 8;

  logic          aclk;
  logic          areset;
  logic [NM-1:0] request_wr;
  logic          s_axil_bvalid;
  logic [NM-1:0] m_axil_bready;

  logic [NM-1:0] rr_grant, fp_grant;
  logic [1:0]    rr_idx, fp_idx;
  logic          rr_act, fp_act, rr_terr, fp_terr;

  int n_pass  = 0;
  int n_total = 0;

  axil_arbiter_rr_wr #(.NUMBER_MASTER(NM), .ARB_MODE(1), .TIMEOUT_CYCLES(TO)) u_rr (
    .aclk(aclk), .areset(areset), .request_wr(request_wr),
    .grant_wr(rr_grant), .grant_idx(rr_idx), .grant_active(rr_act),
    .s_axil_bvalid(s_axil_bvalid), .m_axil_bready(m_axil_bready),
    .timeout_err(rr_terr)
  );

  axil_arbiter_rr_wr #(.NUMBER_MASTER(NM), .ARB_MODE(0), .TIMEOUT_CYCLES(TO)) u_fp (
    .aclk(aclk), .areset(areset), .request_wr(request_wr),
    .grant_wr(fp_grant), .grant_idx(fp_idx), .grant_active(fp_act),
    .s_axil_bvalid(s_axil_bvalid), .m_axil_bready(m_axil_bready),
    .timeout_err(fp_terr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Reference model, index 0 = round-robin instance, 1 = fixed priority.
  // holder: granted master or -1; pending: one arbitration cycle owed;
  // age: ACKN cycles elapsed without release.
  int m_holder [2];
  int m_ptr    [2];
  int m_age    [2];
  bit m_pending[2];
  bit m_terr   [2];

  function automatic int pick(int mode, int ptr, logic [NM-1:0] req);
    int start;
    start = (mode == 1) ? ptr : 0;
    for (int i = 0; i < NM; i++) begin
      if (req[(start + i) % NM]) return (start + i) % NM;
    end
    return -1;
  endfunction

  task automatic model_step(int m);
    int mode;
    bit rel;
    mode = (m == 0) ? 1 : 0;
    if (areset) begin
      m_holder[m] = -1; m_ptr[m] = 0; m_age[m] = 0;
      m_pending[m] = 1'b0; m_terr[m] = 1'b0;
      return;
    end
    m_terr[m] = 1'b0;
    if (m_holder[m] >= 0) begin
      rel = s_axil_bvalid && m_axil_bready[m_holder[m]];
      if (rel || m_age[m] == TO - 1) begin
        m_ptr[m]    = (m_holder[m] + 1) % NM;
        m_holder[m] = -1;
        m_terr[m]   = !rel;
      end else begin
        m_age[m] = m_age[m] + 1;
      end
    end else if (m_pending[m]) begin
      m_pending[m] = 1'b0;
      if (request_wr != 0) begin
        m_holder[m] = pick(mode, m_ptr[m], request_wr);
        m_age[m]    = 0;
      end
    end else begin
      m_pending[m] = (request_wr != 0);
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic cmp_model(int m, logic [NM-1:0] g, logic [1:0] ix, logic a, logic t, int cyc);
    logic [NM-1:0] eg;
    logic [1:0]    ei;
    eg = '0;
    ei = '0;
    if (m_holder[m] >= 0) begin
      eg[m_holder[m]] = 1'b1;
      ei = 2'(m_holder[m]);
    end
    chk($sformatf("rand%0d_c%0d_grant", m, cyc), 32'(g), 32'(eg));
    chk($sformatf("rand%0d_c%0d_idx", m, cyc), 32'(ix), 32'(ei));
    chk($sformatf("rand%0d_c%0d_active", m, cyc), 32'(a), 32'(m_holder[m] >= 0));
    chk($sformatf("rand%0d_c%0d_terr", m, cyc), 32'(t), 32'(m_terr[m]));
  endtask

  task automatic drive(logic rst, logic [NM-1:0] req, logic bv, logic [NM-1:0] br);
    areset        = rst;
    request_wr    = req;
    s_axil_bvalid = bv;
    m_axil_bready = br;
  endtask

  // One clock: the model sees the same inputs the DUTs sample, outputs are
  // read 1 time unit after the edge.
  task automatic tick();
    @(posedge aclk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  typedef struct {
    logic          rst;
    logic [NM-1:0] req;
    logic          bv;
    logic [NM-1:0] br;
    logic [NM-1:0] rr_g;
    logic [1:0]    rr_i;
    logic [NM-1:0] fp_g;
    logic [1:0]    fp_i;
  } vec_t;

  vec_t tbl[20];

  task automatic set_row(int i, logic rst, logic [NM-1:0] req, logic bv, logic [NM-1:0] br,
                         logic [NM-1:0] rg, logic [1:0] ri, logic [NM-1:0] fg, logic [1:0] fi);
    tbl[i].rst = rst; tbl[i].req = req; tbl[i].bv = bv; tbl[i].br = br;
    tbl[i].rr_g = rg; tbl[i].rr_i = ri; tbl[i].fp_g = fg; tbl[i].fp_i = fi;
  endtask

  initial begin
    drive(1'b1, '0, 1'b0, '0);

    // Reset, then all masters requesting with immediate B handshake:
    // three cycles per grant (IDLE, GRANT, one ACKN). Then a one-cycle
    // request that is withdrawn before arbitration.
    set_row( 0, 1, 4'h0, 0, 4'h0, 4'h0, 0, 4'h0, 0);
    set_row( 1, 0, 4'hF, 1, 4'hF, 4'h0, 0, 4'h0, 0);
    set_row( 2, 0, 4'hF, 1, 4'hF, 4'h1, 0, 4'h1, 0);
    set_row( 3, 0, 4'hF, 1, 4'hF, 4'h0, 0, 4'h0, 0);
    set_row( 4, 0, 4'hF, 1, 4'hF, 4'h0, 0, 4'h0, 0);
    set_row( 5, 0, 4'hF, 1, 4'hF, 4'h2, 1, 4'h1, 0);
    set_row( 6, 0, 4'hF, 1, 4'hF, 4'h0, 0, 4'h0, 0);
    set_row( 7, 0, 4'hF, 1, 4'hF, 4'h0, 0, 4'h0, 0);
    set_row( 8, 0, 4'hF, 1, 4'hF, 4'h4, 2, 4'h1, 0);
    set_row( 9, 0, 4'hF, 1, 4'hF, 4'h0, 0, 4'h0, 0);
    set_row(10, 0, 4'hF, 1, 4'hF, 4'h0, 0, 4'h0, 0);
    set_row(11, 0, 4'hF, 1, 4'hF, 4'h8, 3, 4'h1, 0);
    set_row(12, 0, 4'hF, 1, 4'hF, 4'h0, 0, 4'h0, 0);
    set_row(13, 0, 4'hF, 1, 4'hF, 4'h0, 0, 4'h0, 0);
    set_row(14, 0, 4'hF, 1, 4'hF, 4'h1, 0, 4'h1, 0);
    set_row(15, 0, 4'hF, 1, 4'hF, 4'h0, 0, 4'h0, 0);
    set_row(16, 0, 4'h0, 0, 4'h0, 4'h0, 0, 4'h0, 0);
    set_row(17, 0, 4'h2, 0, 4'h0, 4'h0, 0, 4'h0, 0);
    set_row(18, 0, 4'h0, 0, 4'h0, 4'h0, 0, 4'h0, 0);
    set_row(19, 0, 4'h0, 0, 4'h0, 4'h0, 0, 4'h0, 0);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].bv, tbl[i].br);
      tick();
      chk($sformatf("row%0d_rr_grant", i), 32'(rr_grant), 32'(tbl[i].rr_g));
      chk($sformatf("row%0d_rr_idx", i), 32'(rr_idx), 32'(tbl[i].rr_i));
      chk($sformatf("row%0d_rr_active", i), 32'(rr_act), 32'(|tbl[i].rr_g));
      chk($sformatf("row%0d_rr_terr", i), 32'(rr_terr), 32'd0);
      chk($sformatf("row%0d_fp_grant", i), 32'(fp_grant), 32'(tbl[i].fp_g));
      chk($sformatf("row%0d_fp_idx", i), 32'(fp_idx), 32'(tbl[i].fp_i));
    end

    // Grant to master 2; wrong master's bready and request changes are ignored.
    drive(0, 4'b0100, 0, 4'b0000);
    tick();
    chk("m2_grant_latency1", 32'(rr_grant), 32'h0);
    tick();
    chk("m2_rr_grant", 32'(rr_grant), 32'h4);
    chk("m2_rr_idx", 32'(rr_idx), 32'd2);
    chk("m2_fp_grant", 32'(fp_grant), 32'h4);
    drive(0, 4'b1011, 1, 4'b0001);
    tick();
    chk("m2_wrong_bready_a", 32'(rr_grant), 32'h4);
    tick();
    chk("m2_wrong_bready_b", 32'(rr_grant), 32'h4);
    chk("m2_wrong_bready_fp", 32'(fp_grant), 32'h4);
    drive(0, 4'b0000, 1, 4'b0100);
    tick();
    chk("m2_release_rr", 32'(rr_grant), 32'h0);
    chk("m2_release_fp", 32'(fp_grant), 32'h0);
    chk("m2_release_terr", 32'(rr_terr), 32'd0);

    // No handshake: forced release after the 8th ACKN cycle.
    drive(0, 4'b0001, 0, 4'b0000);
    tick();
    tick();
    chk("to_grant", 32'(rr_grant), 32'h1);
    drive(0, 4'b0000, 0, 4'b0000);
    for (int i = 1; i < TO; i++) begin
      tick();
      chk($sformatf("to_hold%0d", i), 32'(rr_grant), 32'h1);
      chk($sformatf("to_hold%0d_terr", i), 32'(rr_terr), 32'd0);
    end
    tick();
    chk("to_release_grant", 32'(rr_grant), 32'h0);
    chk("to_release_terr_rr", 32'(rr_terr), 32'd1);
    chk("to_release_terr_fp", 32'(fp_terr), 32'd1);
    tick();
    chk("to_pulse_end", 32'(rr_terr), 32'd0);
    chk("to_active_off", 32'(rr_act), 32'd0);

    // Handshake in the same cycle as the timeout: no error pulse.
    drive(0, 4'b0010, 0, 4'b0000);
    tick();
    tick();
    chk("hs8_grant", 32'(rr_grant), 32'h2);
    drive(0, 4'b0000, 0, 4'b0000);
    for (int i = 1; i < TO; i++) tick();
    chk("hs8_still_held", 32'(rr_grant), 32'h2);
    drive(0, 4'b0000, 1, 4'b0010);
    tick();
    chk("hs8_release", 32'(rr_grant), 32'h0);
    chk("hs8_terr_rr", 32'(rr_terr), 32'd0);
    chk("hs8_terr_fp", 32'(fp_terr), 32'd0);
    drive(0, 4'b0000, 0, 4'b0000);
    tick();
    chk("hs8_terr_next", 32'(rr_terr), 32'd0);

    // Reset mid-ACKN with a simultaneous handshake; pointer returns to 0.
    drive(0, 4'b1000, 0, 4'b0000);
    tick();
    tick();
    chk("rst_pre_idx", 32'(rr_idx), 32'd3);
    drive(0, 4'b0000, 0, 4'b0000);
    tick();
    drive(1, 4'b0000, 1, 4'b1000);
    tick();
    chk("rst_grant", 32'(rr_grant), 32'h0);
    chk("rst_idx", 32'(rr_idx), 32'd0);
    chk("rst_active", 32'(rr_act), 32'd0);
    chk("rst_terr", 32'(rr_terr), 32'd0);
    drive(0, 4'b1001, 0, 4'b0000);
    tick();
    tick();
    chk("rst_rr_ptr_grant", 32'(rr_grant), 32'h1);
    chk("rst_rr_ptr_idx", 32'(rr_idx), 32'd0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      logic          r_rst;
      logic [NM-1:0] r_req;
      r_rst = ($urandom_range(0, 99) == 0);
      r_req = ($urandom_range(0, 9) < 3) ? 4'h0 : 4'($urandom_range(1, 15));
      drive(r_rst, r_req, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
      tick();
      cmp_model(0, rr_grant, rr_idx, rr_act, rr_terr, c);
      cmp_model(1, fp_grant, fp_idx, fp_act, fp_terr, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
